// File: rtl/even_parity_pkg.sv
// Shared definitions for the even-parity serial link (transmitter, checker, future receiver).
package even_parity_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned FRAME_BITS     = DEFAULT_DATA_W + 3;
  localparam logic        IDLE_LEVEL     = 1'b1;

  // Frame length in bits for a non-default payload width.
  function automatic int unsigned frame_bits(input int unsigned data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/even_parity_serial_tx_bit_tick_counter.sv
// Per-bit down counter: reloads to CLKS_PER_BIT-1 on load and flags tick at zero.
module bit_tick_counter #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tick
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] timer;

  // Holds at zero when not reloaded, so an idle line never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      timer <= '0;
    else if (load)
      timer <= RELOAD;
    else if (timer != '0)
      timer <= timer - 1'b1;
  end

  assign tick = (timer == '0);

endmodule

// File: rtl/even_parity_serial_tx.sv
// Even-parity serial transmitter: start, DATA_W bits LSB first, parity, stop.
module even_parity_serial_tx
  import even_parity_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              busy,
  output logic              parity_out
);

  localparam int unsigned IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nxt;
  logic [IW-1:0]     idx;
  logic              tick;
  logic              accept;
  logic              load;

  assign ready_out = (state == IDLE) || ((state == STOP) && tick);
  assign accept    = valid_in && ready_out;
  assign busy      = (state != IDLE);
  assign shift_nxt = shift >> 1;
  assign load      = accept ||
                     (tick && ((state == START) || (state == DATA) || (state == PARITY)));

  bit_tick_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .tick (tick)
  );

  // tx_out is loaded with the level of the state being entered, so it is valid
  // for the whole first cycle of each bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift      <= '0;
      idx        <= '0;
      tx_out     <= IDLE_LEVEL;
      parity_out <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        START: if (tick) begin
          state  <= DATA;
          idx    <= '0;
          tx_out <= shift[0];
        end
        DATA: if (tick) begin
          shift <= shift_nxt;
          if (idx == LAST_IDX) begin
            state  <= PARITY;
            tx_out <= parity_out;
          end else begin
            idx    <= idx + 1'b1;
            tx_out <= shift_nxt[0];
          end
        end
        PARITY: if (tick) begin
          state  <= STOP;
          tx_out <= IDLE_LEVEL;
        end
        STOP: if (tick) begin
          state  <= IDLE;
          tx_out <= IDLE_LEVEL;
        end
        default: begin
          state  <= IDLE;
          tx_out <= IDLE_LEVEL;
        end
      endcase
      // Accept (from IDLE, or STOP on its final cycle) overrides the case above.
      if (accept) begin
        state      <= START;
        shift      <= data_in;
        parity_out <= ^data_in;
        idx        <= '0;
        tx_out     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Self-checking bench: per-cycle expected line levels from a queue-based frame model.
module tb_even_parity_serial_tx;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CPB       = 4;
  localparam int unsigned FRAME_CYC = (DATA_W + 3) * CPB;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DATA_W-1:0] data_in = '0;
  logic              valid_in = 1'b0;
  logic              ready_out, tx_out, busy, parity_out;

  even_parity_serial_tx #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .tx_out    (tx_out),
    .busy      (busy),
    .parity_out(parity_out)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  bit q[$];
  logic exp_tx = 1'b1, exp_ready = 1'b1, exp_busy = 1'b0, exp_par = 1'b0;
  logic rx_x = 1'b0;
  int unsigned n_acc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: model accept decision, push frame, pop current line level, compare.
  task automatic step();
    bit acc;
    logic [DATA_W-1:0] d;
    int unsigned pos, bitn;
    acc = valid_in && exp_ready;
    d   = data_in;
    @(posedge clk);
    if (acc) begin
      n_acc++;
      exp_par = ^d;
      for (int unsigned c = 0; c < CPB; c++) q.push_back(1'b0);
      for (int unsigned b = 0; b < DATA_W; b++)
        for (int unsigned c = 0; c < CPB; c++) q.push_back(d[b]);
      for (int unsigned c = 0; c < CPB; c++) q.push_back(^d);
      for (int unsigned c = 0; c < CPB; c++) q.push_back(1'b1);
    end
    if (q.size() != 0) begin
      exp_tx   = q.pop_front();
      exp_busy = 1'b1;
    end else begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end
    exp_ready = (q.size() == 0);
    #1;
    check_eq("tx_out", tx_out, exp_tx);
    check_eq("ready_out", ready_out, exp_ready);
    check_eq("busy", busy, exp_busy);
    check_eq("parity_out", parity_out, exp_par);
    // Far-end checker: sample mid-bit, XOR data+parity, expect zero.
    if (exp_busy) begin
      pos  = FRAME_CYC - 1 - q.size();
      bitn = pos / CPB;
      if (pos % CPB == CPB / 2) begin
        if (bitn == 0) rx_x = 1'b0;
        else if (bitn <= DATA_W + 1) rx_x ^= tx_out;
        if (bitn == DATA_W + 1) check_eq("rx_parity_err", rx_x, 1'b0);
      end
    end
  endtask

  task automatic send_one(input logic [DATA_W-1:0] d);
    int unsigned low;
    valid_in = 1'b1;
    data_in  = d;
    step();
    valid_in = 1'b0;
    data_in  = $urandom;
    low = (ready_out == 1'b0) ? 1 : 0;
    for (int unsigned i = 1; i < FRAME_CYC + 2; i++) begin
      step();
      if (busy && !ready_out) low++;
    end
    check_eq("ready_low_cycles", low, FRAME_CYC - 1);
  endtask

  task automatic wait_acc(input int unsigned target);
    int unsigned n = 0;
    while (n_acc < target && n < 3 * FRAME_CYC) begin
      step();
      n++;
    end
    if (n_acc < target) check_eq("accept_timeout", n_acc, target);
  endtask

  initial begin
    // Reset then idle
    #2 rst_n = 1'b0;
    #1 check_eq("reset_tx_async", tx_out, 1'b1);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();

    send_one(8'hA5);
    send_one(8'h07);
    send_one(8'hFF);
    send_one(8'h00);

    // Back-to-back: valid held high, second frame starts right after stop.
    valid_in = 1'b1;
    data_in  = 8'h01;
    wait_acc(n_acc + 1);
    data_in  = 8'h80;
    wait_acc(n_acc + 1);
    valid_in = 1'b0;
    repeat (FRAME_CYC + 2) step();

    // Handshake stall: data changes while the first frame is in flight.
    valid_in = 1'b1;
    data_in  = 8'h3C;
    wait_acc(n_acc + 1);
    repeat (10) step();
    data_in = 8'hC3;
    wait_acc(n_acc + 1);
    valid_in = 1'b0;
    repeat (FRAME_CYC + 2) step();

    // Reset mid-frame during data bit 3
    valid_in = 1'b1;
    data_in  = 8'h5A;
    step();
    valid_in = 1'b0;
    repeat (CPB + 3 * CPB + 1) step();
    check_eq("pre_reset_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_reset_tx", tx_out, 1'b1);
    check_eq("mid_reset_busy", busy, 1'b0);
    q.delete();
    exp_ready = 1'b1;
    exp_par   = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    send_one(8'h5A);

    // Random traffic with random gaps
    for (int unsigned i = 0; i < 1500; i++) begin
      valid_in = ($urandom_range(0, 3) == 0);
      data_in  = DATA_W'($urandom);
      step();
    end
    valid_in = 1'b0;
    repeat (FRAME_CYC + 2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
